fir_sample_feeder: RTL and testbench

- Transmitter side of the FIR sample interface. Drives a filter's inputValid/FIR_input pair and consumes its outputValid.
- Buffers upstream samples in a small FIFO. Issues exactly one sample per filter computation, and waits for outputValid before issuing the next, because the filter is a serial multi-cycle MAC.
- Sits between a sample source (ADC capture, testbench ROM) and the filter.

---
 rtl/fir_sample_feeder_if.sv | 25 ++
 rtl/fir_sample_feeder.sv | 137 +++++++++++++
 tb/tb_fir_sample_feeder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_sample_feeder_if.sv
// Sample handshake bundle between the upstream source, the feeder and the FIR
// filter. The feeder takes the slave view; the environment that owns the
// source and the filter takes the master view.
interface fir_sample_feeder_if #(
  parameter int InputWidth = 16
);
  logic                  in_valid;
  logic [InputWidth-1:0] in_data;
  logic                  in_ready;
  logic                  inputValid;
  logic [InputWidth-1:0] FIR_input;
  logic                  outputValid;

  // Environment side: produces samples and the filter's done pulse.
  modport master (
    output in_valid, in_data, outputValid,
    input  in_ready, inputValid, FIR_input
  );

  // Feeder side: accepts samples and strobes them into the filter.
  modport slave (
    input  in_valid, in_data, outputValid,
    output in_ready, inputValid, FIR_input
  );
endinterface

// File: rtl/fir_sample_feeder.sv
// FIR sample feeder: buffers upstream samples in a small circular FIFO and
// hands them to a serial multi-cycle filter one at a time, waiting for the
// filter's done pulse (or a timeout) before issuing the next sample.
module fir_sample_feeder #(
  parameter int InputWidth = 16,
  parameter int FIFO_depth = 16,
  parameter int Timeout    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  fir_sample_feeder_if.slave            bus,
  output logic                          busy,
  output logic [$clog2(FIFO_depth):0]   level,
  output logic                          timeout_err,
  output logic [15:0]                   sent_count
);

  localparam int PtrW = $clog2(FIFO_depth);
  localparam int LvlW = PtrW + 1;
  // Wide enough to hold Timeout-1; Timeout=1 still yields a 1-bit counter.
  localparam int CntW = $clog2(Timeout + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                state_reg;
  logic [InputWidth-1:0] mem [FIFO_depth];
  logic [PtrW-1:0]       wr_ptr_reg;
  logic [PtrW-1:0]       rd_ptr_reg;
  logic [LvlW-1:0]       level_reg;
  logic [CntW-1:0]       wait_cnt_reg;
  logic [InputWidth-1:0] fir_input_reg;
  logic                  input_valid_reg;
  logic                  busy_reg;
  logic                  timeout_err_reg;
  logic [15:0]           sent_count_reg;

  logic full;
  logic wr_en;
  logic pop;

  // Writes are refused whenever full, even if a pop happens on the same edge,
  // so in_ready depends only on the current occupancy.
  assign full  = (level_reg == LvlW'(FIFO_depth));
  assign wr_en = bus.in_valid && !full;
  // The only consumer of FIFO entries is the IDLE->SEND transition.
  assign pop   = (state_reg == IDLE) && (level_reg != '0);

  assign bus.in_ready   = !full;
  assign bus.inputValid = input_valid_reg;
  assign bus.FIR_input  = fir_input_reg;
  assign busy           = busy_reg;
  assign level          = level_reg;
  assign timeout_err    = timeout_err_reg;
  assign sent_count     = sent_count_reg;

  // Sample storage; left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= bus.in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   level_reg <= level_reg + LvlW'(1);
        2'b01:   level_reg <= level_reg - LvlW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Handshake FSM with registered outputs: one strobe per sample, then wait
  // for the filter's done pulse or give up after Timeout cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      fir_input_reg   <= '0;
      input_valid_reg <= 1'b0;
      busy_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      sent_count_reg  <= '0;
      wait_cnt_reg    <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (pop) begin
            state_reg       <= SEND;
            fir_input_reg   <= mem[rd_ptr_reg];
            input_valid_reg <= 1'b1;
            busy_reg        <= 1'b1;
          end
        end
        SEND: begin
          state_reg       <= WAIT;
          input_valid_reg <= 1'b0;
          wait_cnt_reg    <= '0;
        end
        WAIT: begin
          // A done pulse wins over a timeout landing on the same cycle.
          if (bus.outputValid) begin
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
            sent_count_reg <= sent_count_reg + 16'd1;
          end else if (wait_cnt_reg == CntW'(Timeout - 1)) begin
            state_reg       <= IDLE;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b1;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CntW'(1);
          end
        end
        default: begin
          state_reg       <= IDLE;
          input_valid_reg <= 1'b0;
          busy_reg        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Bench for fir_sample_feeder: two instances (long and short timeout) share the
// same stimulus; a queue-based reference model predicts every output each cycle.
module tb_fir_sample_feeder;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int TA = 255;
  localparam int TB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          drv_rst   = 1'b1;
  logic          drv_valid = 1'b0;
  logic [W-1:0]  drv_data  = '0;
  logic          drv_ov    = 1'b0;

  fir_sample_feeder_if #(.InputWidth(W)) bus_a ();
  fir_sample_feeder_if #(.InputWidth(W)) bus_b ();

  assign bus_a.in_valid    = drv_valid;
  assign bus_a.in_data     = drv_data;
  assign bus_a.outputValid = drv_ov;
  assign bus_b.in_valid    = drv_valid;
  assign bus_b.in_data     = drv_data;
  assign bus_b.outputValid = drv_ov;

  logic        busy_a, busy_b, err_a, err_b;
  logic [4:0]  level_a, level_b;
  logic [15:0] sent_a, sent_b;

  fir_sample_feeder #(.InputWidth(W), .FIFO_depth(D), .Timeout(TA)) dut_a (
    .clk(clk), .rst(drv_rst), .bus(bus_a.slave),
    .busy(busy_a), .level(level_a), .timeout_err(err_a), .sent_count(sent_a)
  );

  fir_sample_feeder #(.InputWidth(W), .FIFO_depth(D), .Timeout(TB)) dut_b (
    .clk(clk), .rst(drv_rst), .bus(bus_b.slave),
    .busy(busy_b), .level(level_b), .timeout_err(err_b), .sent_count(sent_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model, one slot per instance. Phase: 0 idle, 1 strobe, 2 waiting.
  logic [W-1:0] mq [2][64];
  int           mhd [2];
  int           mtl [2];
  int           mph [2];
  int           mel [2];
  int           msent [2];
  logic [W-1:0] mfir [2];
  bit           merr [2];
  int           mto [2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_step(int d);
    int cnt;
    bit wr;
    cnt = mtl[d] - mhd[d];
    wr  = drv_valid && (cnt < D);
    if (drv_rst) begin
      mhd[d] = 0; mtl[d] = 0; mph[d] = 0; mel[d] = 0;
      msent[d] = 0; mfir[d] = '0; merr[d] = 1'b0;
    end else begin
      case (mph[d])
        0: if (cnt > 0) begin
             mfir[d] = mq[d][mhd[d] % 64];
             mhd[d]++;
             mph[d] = 1;
           end
        1: begin
             mph[d] = 2;
             mel[d] = 0;
           end
        default: begin
          mel[d]++;
          if (drv_ov) begin
            msent[d] = (msent[d] + 1) % 65536;
            mph[d]   = 0;
          end else if (mel[d] == mto[d]) begin
            merr[d] = 1'b1;
            mph[d]  = 0;
          end
        end
      endcase
      if (wr) begin
        mq[d][mtl[d] % 64] = drv_data;
        mtl[d]++;
      end
    end
  endtask

  task automatic cmp_dut(int d, logic rdy, logic iv, logic [W-1:0] fir, logic bz,
                         logic [4:0] lv, logic er, logic [15:0] sc);
    int cnt;
    cnt = mtl[d] - mhd[d];
    check($sformatf("in_ready_%0d", d),    32'(rdy), 32'(cnt < D));
    check($sformatf("inputValid_%0d", d),  32'(iv),  32'(mph[d] == 1));
    check($sformatf("FIR_input_%0d", d),   32'(fir), 32'(mfir[d]));
    check($sformatf("busy_%0d", d),        32'(bz),  32'(mph[d] != 0));
    check($sformatf("level_%0d", d),       32'(lv),  32'(cnt));
    check($sformatf("timeout_err_%0d", d), 32'(er),  32'(merr[d]));
    check($sformatf("sent_count_%0d", d),  32'(sc),  32'(msent[d]));
  endtask

  // One clock: update model, let the edge pass, compare away from the edge.
  task automatic cyc();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    cmp_dut(0, bus_a.in_ready, bus_a.inputValid, bus_a.FIR_input, busy_a, level_a, err_a, sent_a);
    cmp_dut(1, bus_b.in_ready, bus_b.inputValid, bus_b.FIR_input, busy_b, level_b, err_b, sent_b);
  endtask

  task automatic cycs(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    mto[0] = TA;
    mto[1] = TB;
    for (int d = 0; d < 2; d++) begin
      mhd[d] = 0; mtl[d] = 0; mph[d] = 0; mel[d] = 0;
      msent[d] = 0; mfir[d] = '0; merr[d] = 1'b0;
    end

    // Reset state.
    drv_rst = 1'b1;
    cycs(2);
    check("rst_level", 32'(level_a), 32'd0);
    check("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    drv_rst = 1'b0;

    // Single sample: strobe appears one cycle after the write edge.
    cycs(3);
    drv_valid = 1'b1; drv_data = 16'h1234;
    cyc();
    drv_valid = 1'b0; drv_data = '0;
    cyc();
    check("single_strobe", 32'(bus_a.inputValid), 32'd1);
    check("single_data", 32'(bus_a.FIR_input), 32'h1234);
    cyc();
    check("single_strobe_off", 32'(bus_a.inputValid), 32'd0);
    cycs(68);
    drv_ov = 1'b1;
    cyc();
    drv_ov = 1'b0;
    cyc();
    check("single_sent", 32'(sent_a), 32'd1);
    check("single_busy", 32'(busy_a), 32'd0);
    check("single_level", 32'(level_a), 32'd0);

    // Burst fill of 20 samples with no done pulses.
    for (int k = 0; k < 20; k++) begin
      drv_valid = 1'b1; drv_data = W'(k + 1);
      cyc();
    end
    drv_valid = 1'b0;
    cyc();
    check("burst_level", 32'(level_a), 32'd16);
    check("burst_in_ready", 32'(bus_a.in_ready), 32'd0);
    check("burst_first", 32'(bus_a.FIR_input), 32'h0001);

    // Release samples one done pulse at a time; random input noise while waiting.
    for (int k = 0; k < 24; k++) begin
      int gap;
      gap = int'($urandom_range(3, 25));
      for (int g = 0; g < gap; g++) begin
        drv_valid = 1'($urandom);
        drv_data  = W'($urandom);
        cyc();
      end
      drv_valid = 1'b0;
      drv_ov = 1'b1;
      cyc();
      drv_ov = 1'b0;
    end
    cycs(5);

    // Timeout on the short-timeout instance; the next queued sample still issues.
    drv_rst = 1'b1;
    cyc();
    drv_rst = 1'b0;
    drv_valid = 1'b1; drv_data = 16'hA5A5;
    cyc();
    drv_data = 16'h5A5A;
    cyc();
    drv_valid = 1'b0;
    cycs(10);
    check("to_still_busy", 32'(busy_b), 32'd1);
    check("to_err_early", 32'(err_b), 32'd0);
    cyc();
    check("to_err_set", 32'(err_b), 32'd1);
    check("to_idle", 32'(busy_b), 32'd0);
    check("to_sent", 32'(sent_b), 32'd0);
    cyc();
    check("to_next_strobe", 32'(bus_b.inputValid), 32'd1);
    check("to_next_data", 32'(bus_b.FIR_input), 32'h5A5A);
    cycs(20);
    check("to_err_sticky", 32'(err_b), 32'd1);
    check("to_long_no_err", 32'(err_a), 32'd0);

    // Spurious done while idle, then done on the last possible wait cycle.
    drv_rst = 1'b1;
    cyc();
    drv_rst = 1'b0;
    drv_ov = 1'b1;
    cyc();
    drv_ov = 1'b0;
    check("spurious_sent", 32'(sent_b), 32'd0);
    drv_valid = 1'b1; drv_data = 16'hBEEF;
    cyc();
    drv_valid = 1'b0;
    cycs(11);
    drv_ov = 1'b1;
    cyc();
    drv_ov = 1'b0;
    check("prio_sent", 32'(sent_b), 32'd1);
    check("prio_err", 32'(err_b), 32'd0);
    cyc();

    // Reset mid-handshake discards queue and in-flight sample.
    drv_rst = 1'b1;
    cyc();
    drv_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drv_valid = 1'b1; drv_data = W'(16'h0100 + k);
      cyc();
    end
    drv_valid = 1'b0;
    cycs(2);
    check("mid_busy", 32'(busy_a), 32'd1);
    drv_rst = 1'b1;
    cyc();
    drv_rst = 1'b0;
    check("mid_level", 32'(level_a), 32'd0);
    check("mid_fir", 32'(bus_a.FIR_input), 32'd0);
    drv_ov = 1'b1;
    cyc();
    drv_ov = 1'b0;
    cycs(3);
    check("mid_sent", 32'(sent_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
